// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with registered accept/reject pulses and
// occupancy-derived status flags.
// Optional feature macro: FIFO_FWFT_EN selects first-word-fall-through reads;
// when undefined, reads are registered (data_out valid one cycle after rd_en).
module param_sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [FIFO_WIDTH-1:0]           data_in,
  input  logic                            wr_en,
  input  logic                            rd_en,
  output logic [FIFO_WIDTH-1:0]           data_out,
  output logic                            rd_valid,
  output logic                            wr_ack,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            full,
  output logic                            empty,
  output logic                            almostfull,
  output logic                            almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Reject illegal threshold settings at elaboration time.
  if (AF_THRESH > FIFO_DEPTH || AE_THRESH >= FIFO_DEPTH) begin : g_bad_thresh
    $error("param_sync_fifo: AF_THRESH must be <= FIFO_DEPTH and AE_THRESH < FIFO_DEPTH");
  end

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_ack_q, wr_ack_d, overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;

  assign count       = count_q;
  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CNT_W'(AF_THRESH));
  assign almostempty = (count_q != '0) && (count_q <= CNT_W'(AE_THRESH));
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // Accept decisions, next pointers, occupancy and request pulses.
  always_comb begin
    rd_acc      = rd_en && !empty;
    // A full FIFO still takes a write when a read frees the slot this cycle.
    wr_acc      = wr_en && (!full || rd_acc);
    wr_ptr_d    = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    wr_ack_d    = wr_acc;
    overflow_d  = wr_en && !wr_acc;
    underflow_d = rd_en && !rd_acc;
  end

  // Control state; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array: not reset, written only on an accepted write outside reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible whenever the FIFO holds data.
  always_comb begin
    data_out = empty ? '0 : mem_q[rd_ptr_q];
    rd_valid = !empty;
  end
`else
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;

  // Registered read path: capture the head word on an accepted read, else hold.
  always_comb begin
    data_out_d = rd_acc ? mem_q[rd_ptr_q] : data_out_q;
    rd_valid_d = rd_acc;
  end

  // Read data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: a queue-based model checked every
// cycle, plus directed vectors with literal expectations.
module tb_param_sync_fifo;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AF = D - 2;
  localparam int AE = 2;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [W-1:0]  data_out;
  logic          rd_valid, wr_ack, overflow, underflow;
  logic          full, empty, almostfull, almostempty;
  logic [CW-1:0] count;

  int nvec  = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  param_sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .rd_valid(rd_valid), .wr_ack(wr_ack), .overflow(overflow),
    .underflow(underflow), .full(full), .empty(empty), .almostfull(almostfull),
    .almostempty(almostempty), .count(count)
  );

  always #5 clk = ~clk;

  // Behavioural model: the FIFO is just a queue of words.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  bit           m_rdv = 0, m_ack = 0, m_ovf = 0, m_udf = 0;

  always @(posedge clk) begin
    bit rok, wok;
    if (rst) begin
      q.delete();
      m_dout = '0; m_rdv = 0; m_ack = 0; m_ovf = 0; m_udf = 0;
    end else begin
      rok = rd_en && (q.size() > 0);
      wok = wr_en && ((q.size() < D) || rok);
      m_rdv = rok;
      if (rok) m_dout = q.pop_front();
      if (wok) q.push_back(data_in);
      m_ack = wok;
      m_ovf = wr_en && !wok;
      m_udf = rd_en && !rok;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int n;
    if (chk_en) begin
      n = q.size();
      chk("m_count", 64'(count), 64'(n));
      chk("m_full", 64'(full), 64'(n == D));
      chk("m_empty", 64'(empty), 64'(n == 0));
      chk("m_afull", 64'(almostfull), 64'(n >= AF));
      chk("m_aempty", 64'(almostempty), 64'(n != 0 && n <= AE));
      chk("m_wr_ack", 64'(wr_ack), 64'(m_ack));
      chk("m_overflow", 64'(overflow), 64'(m_ovf));
      chk("m_underflow", 64'(underflow), 64'(m_udf));
`ifdef FIFO_FWFT_EN
      chk("m_rd_valid", 64'(rd_valid), 64'(n != 0));
      chk("m_data_out", 64'(data_out), (n != 0) ? 64'(q[0]) : 64'd0);
`else
      chk("m_rd_valid", 64'(rd_valid), 64'(m_rdv));
      chk("m_data_out", 64'(data_out), 64'(m_dout));
`endif
    end
  end

  // Apply one cycle of inputs; returns 2 time units after the consuming edge.
  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r);
    wr_en = w; data_in = d; rd_en = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0);
    chk_en = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_af", 64'(almostfull), 64'd0);
    chk("rst_ae", 64'(almostempty), 64'd0);
    chk("rst_dout", 64'(data_out), 64'd0);
    chk("rst_rdv", 64'(rd_valid), 64'd0);
    rst = 1'b0;

    // Fill 0x0001..0x0008
    for (int i = 1; i <= D; i++) begin
      cyc(1'b1, W'(i), 1'b0);
      chk("fill_count", 64'(count), 64'(i));
      chk("fill_ack", 64'(wr_ack), 64'd1);
      chk("fill_af", 64'(almostfull), 64'(i >= 6));
      chk("fill_full", 64'(full), 64'(i == 8));
    end

    // Overflow with 0xDEAD
    cyc(1'b1, 16'hDEAD, 1'b0);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_ack", 64'(wr_ack), 64'd0);
    chk("ovf_count", 64'(count), 64'd8);
    cyc(1'b0, '0, 1'b0);
    chk("ovf_clear", 64'(overflow), 64'd0);

    // Drain 8 words
    for (int i = 1; i <= D; i++) begin
`ifdef FIFO_FWFT_EN
      chk("drain_head", 64'(data_out), 64'(i));
`endif
      cyc(1'b0, '0, 1'b1);
`ifndef FIFO_FWFT_EN
      chk("drain_dout", 64'(data_out), 64'(i));
      chk("drain_rdv", 64'(rd_valid), 64'd1);
`endif
      chk("drain_count", 64'(count), 64'(8 - i));
      chk("drain_ae", 64'(almostempty), 64'((8 - i) == 2 || (8 - i) == 1));
      chk("drain_empty", 64'(empty), 64'(i == 8));
    end

    // Underflow
    cyc(1'b0, '0, 1'b1);
    chk("udf_flag", 64'(underflow), 64'd1);
    chk("udf_count", 64'(count), 64'd0);
    cyc(1'b0, '0, 1'b0);
    chk("udf_clear", 64'(underflow), 64'd0);
    chk("udf_rdv", 64'(rd_valid), 64'd0);

    // Simultaneous access on empty: write wins, read rejected
    cyc(1'b1, 16'h0055, 1'b1);
    chk("esim_count", 64'(count), 64'd1);
    chk("esim_udf", 64'(underflow), 64'd1);
    chk("esim_ack", 64'(wr_ack), 64'd1);
    cyc(1'b0, '0, 1'b1);
`ifndef FIFO_FWFT_EN
    chk("esim_dout", 64'(data_out), 64'h55);
`endif

    // Pointers now offset by one; fill, then simultaneous access when full
    for (int i = 0; i < D; i++) cyc(1'b1, W'(16'h0010 + i), 1'b0);
    chk("fsim_pre", 64'(count), 64'd8);
    cyc(1'b1, 16'h00AA, 1'b1);
    chk("fsim_count", 64'(count), 64'd8);
    chk("fsim_ovf", 64'(overflow), 64'd0);
    chk("fsim_ack", 64'(wr_ack), 64'd1);
`ifndef FIFO_FWFT_EN
    chk("fsim_dout", 64'(data_out), 64'h10);
`endif
    for (int i = 1; i <= D; i++) begin
      cyc(1'b0, '0, 1'b1);
`ifndef FIFO_FWFT_EN
      chk("fsim_drain", 64'(data_out), (i == D) ? 64'hAA : 64'(16'h0010 + i));
`endif
    end
    chk("fsim_empty", 64'(empty), 64'd1);

    // Mid-operation reset at count 5, with requests pending in the same cycle
    for (int i = 0; i < 5; i++) cyc(1'b1, W'(16'h0100 + i), 1'b0);
    chk("mrst_pre", 64'(count), 64'd5);
    rst = 1'b1;
    cyc(1'b1, 16'h0BAD, 1'b1);
    rst = 1'b0;
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_empty", 64'(empty), 64'd1);
    chk("mrst_ack", 64'(wr_ack), 64'd0);
    chk("mrst_ovf", 64'(overflow), 64'd0);
    chk("mrst_udf", 64'(underflow), 64'd0);
    chk("mrst_rdv", 64'(rd_valid), 64'd0);

    // Single write into empty FIFO
    cyc(1'b1, 16'h1234, 1'b0);
`ifdef FIFO_FWFT_EN
    chk("fwft_dout", 64'(data_out), 64'h1234);
    chk("fwft_rdv", 64'(rd_valid), 64'd1);
`else
    chk("std_norv", 64'(rd_valid), 64'd0);
    chk("std_hold", 64'(data_out), 64'd0);
`endif
    cyc(1'b0, '0, 1'b0);

    // Mixed traffic, checked by the per-cycle model compare
    for (int i = 0; i < 60; i++)
      cyc(1'b1 && (i % 3 != 0), W'(i * 16'h0101), (i % 2 == 1) || (i > 40));
    cyc(1'b0, '0, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
